// File: rtl/battle_turn_sequencer_if.sv
// Signal bundle between keypad decode / combat engine and battle_turn_sequencer.
// master = stimulus side (keypad + engine), slave = the sequencer itself.
interface battle_turn_sequencer_if;
    logic       collision_detected;
    logic       key_valid;
    logic [1:0] key_choice;
    logic [4:0] player_sword_left;
    logic [4:0] player_bat_left;
    logic [4:0] enemy_sword_left;
    logic [4:0] enemy_bat_left;
    logic       player_win_in;
    logic       enemy_win_in;
    logic       player_turn;
    logic       attacker_turn;
    logic [1:0] player_choice;
    logic [1:0] enemy_choice;
    logic       battle_active;
    logic       awaiting_key;
    logic [7:0] turn_count;
    logic       battle_over;
    logic       winner;

    modport master (
        output collision_detected, key_valid, key_choice,
               player_sword_left, player_bat_left, enemy_sword_left, enemy_bat_left,
               player_win_in, enemy_win_in,
        input  player_turn, attacker_turn, player_choice, enemy_choice,
               battle_active, awaiting_key, turn_count, battle_over, winner
    );

    modport slave (
        input  collision_detected, key_valid, key_choice,
               player_sword_left, player_bat_left, enemy_sword_left, enemy_bat_left,
               player_win_in, enemy_win_in,
        output player_turn, attacker_turn, player_choice, enemy_choice,
               battle_active, awaiting_key, turn_count, battle_over, winner
    );
endinterface

// File: rtl/battle_turn_sequencer.sv
// Battle turn sequencer: alternates player/enemy strikes, picks enemy attacks from an LFSR, declares the winner.
// Optional feature macro TURN_TIMEOUT_EN: forces a punch (P) strike after TIMEOUT_CYC idle cycles in PLAYER_WAIT.
module battle_turn_sequencer #(
    parameter int         SETTLE_CYC  = 3,
    parameter int         THINK_CYC   = 8,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    battle_turn_sequencer_if.slave seq
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_PWAIT, S_PSTRIKE, S_PSETTLE,
        S_ETHINK, S_ESTRIKE, S_ESETTLE, S_OVER
    } state_t;

    localparam int CNT_MAX = (SETTLE_CYC > THINK_CYC) ? SETTLE_CYC : THINK_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] THINK_LAST  = CW'(THINK_CYC - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    lfsr_q;
    logic [7:0]    lfsr_d;
    logic          coll_q;
    logic          player_turn_q;
    logic          attacker_turn_q;
    logic [1:0]    player_choice_q;
    logic [1:0]    enemy_choice_q;
    logic          active_q;
    logic          await_q;
    logic [7:0]    turns_q;
    logic [7:0]    turns_inc;
    logic          over_q;
    logic          winner_q;

    logic          start;
    logic          leave;
    logic          key_accept;
    logic [1:0]    enemy_pick;
    logic          tmo_fire;

    // Right-shift Galois form of x^8+x^6+x^5+x^4+1.
    assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

    assign start = seq.collision_detected & ~coll_q;
    // Losing the collision ends any battle; in OVER this is the normal exit.
    assign leave = ~seq.collision_detected & (state_q != S_IDLE);

    assign key_accept = seq.key_valid &
                        (~seq.key_choice[1] |
                         (seq.key_choice[0] ? (|seq.player_sword_left) : (|seq.player_bat_left)));

    always_comb begin
        enemy_pick = lfsr_q[1:0];
        if ((lfsr_q[1:0] == 2'b10 && seq.enemy_bat_left == 5'd0) ||
            (lfsr_q[1:0] == 2'b11 && seq.enemy_sword_left == 5'd0))
            enemy_pick = 2'b01;
    end

    assign turns_inc = (turns_q == 8'hFF) ? turns_q : turns_q + 8'd1;

`ifdef TURN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tmo_q;

    // Held at zero outside PLAYER_WAIT so every wait starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst || state_q != S_PWAIT)
            tmo_q <= '0;
        else
            tmo_q <= tmo_q + 1'b1;
    end

    assign tmo_fire = (state_q == S_PWAIT) && (tmo_q == TMO_LAST);
`else
    // Timeout disabled: never fires; the parameter is only referenced to keep overrides legal.
    assign tmo_fire = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            lfsr_q          <= LFSR_SEED;
            coll_q          <= 1'b0;
            player_turn_q   <= 1'b0;
            attacker_turn_q <= 1'b0;
            player_choice_q <= 2'b00;
            enemy_choice_q  <= 2'b00;
            active_q        <= 1'b0;
            await_q         <= 1'b0;
            turns_q         <= 8'd0;
            over_q          <= 1'b0;
            winner_q        <= 1'b0;
        end else begin
            lfsr_q          <= lfsr_d;
            coll_q          <= seq.collision_detected;
            player_turn_q   <= 1'b0;
            attacker_turn_q <= 1'b0;

            if (leave) begin
                state_q         <= S_IDLE;
                cnt_q           <= '0;
                player_choice_q <= 2'b00;
                enemy_choice_q  <= 2'b00;
                active_q        <= 1'b0;
                await_q         <= 1'b0;
                turns_q         <= 8'd0;
                over_q          <= 1'b0;
                winner_q        <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q  <= S_START;
                            active_q <= 1'b1;
                            turns_q  <= 8'd0;
                        end
                    end
                    S_START: begin
                        state_q <= S_PWAIT;
                        await_q <= 1'b1;
                    end
                    S_PWAIT: begin
                        if (key_accept || tmo_fire) begin
                            state_q         <= S_PSTRIKE;
                            await_q         <= 1'b0;
                            player_turn_q   <= 1'b1;
                            turns_q         <= turns_inc;
                            player_choice_q <= key_accept ? seq.key_choice : 2'b00;
                        end
                    end
                    S_PSTRIKE: begin
                        state_q <= S_PSETTLE;
                        cnt_q   <= '0;
                    end
                    S_PSETTLE: begin
                        if (cnt_q == SETTLE_LAST) begin
                            if (seq.player_win_in || seq.enemy_win_in) begin
                                state_q  <= S_OVER;
                                over_q   <= 1'b1;
                                active_q <= 1'b0;
                                winner_q <= seq.player_win_in;
                            end else begin
                                state_q <= S_ETHINK;
                                cnt_q   <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_ETHINK: begin
                        if (cnt_q == THINK_LAST) begin
                            state_q         <= S_ESTRIKE;
                            attacker_turn_q <= 1'b1;
                            turns_q         <= turns_inc;
                            enemy_choice_q  <= enemy_pick;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_ESTRIKE: begin
                        state_q <= S_ESETTLE;
                        cnt_q   <= '0;
                    end
                    S_ESETTLE: begin
                        if (cnt_q == SETTLE_LAST) begin
                            // Enemy win has priority after the enemy's own strike.
                            if (seq.player_win_in || seq.enemy_win_in) begin
                                state_q  <= S_OVER;
                                over_q   <= 1'b1;
                                active_q <= 1'b0;
                                winner_q <= ~seq.enemy_win_in;
                            end else begin
                                state_q <= S_PWAIT;
                                await_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_OVER: begin
                        state_q <= S_OVER;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign seq.player_turn   = player_turn_q;
    assign seq.attacker_turn = attacker_turn_q;
    assign seq.player_choice = player_choice_q;
    assign seq.enemy_choice  = enemy_choice_q;
    assign seq.battle_active = active_q;
    assign seq.awaiting_key  = await_q;
    assign seq.turn_count    = turns_q;
    assign seq.battle_over   = over_q;
    assign seq.winner        = winner_q;

endmodule

// File: tb/tb_battle_turn_sequencer.sv
// Self-checking bench for battle_turn_sequencer: cycle-level reference model, directed corner cases,
// a key-legality vector table and randomized battles. Build with +define+TURN_TIMEOUT_EN to cover the timeout.
module tb_battle_turn_sequencer;

    localparam int         SET  = 3;
    localparam int         THK  = 8;
    localparam int         TMO  = 4;
    localparam logic [7:0] SEED = 8'hA5;
`ifdef TURN_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int PH_IDLE = 0, PH_START = 1, PH_WAIT = 2, PH_PSTRIKE = 3, PH_PSETTLE = 4,
                   PH_THINK = 5, PH_ESTRIKE = 6, PH_ESETTLE = 7, PH_OVER = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    battle_turn_sequencer_if bus ();

    battle_turn_sequencer #(
        .SETTLE_CYC (SET),
        .THINK_CYC  (THK),
        .LFSR_SEED  (SEED),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seq(bus)
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int m_cyc    = 0;

    // Reference model state: battle phase, cycles left in a timed phase, wait cycles spent.
    int         m_ph, m_left, m_idle, m_turns;
    logic [7:0] m_lfsr;
    logic       m_prev, m_win;
    logic [1:0] m_pch, m_ech;

    typedef struct {
        logic [1:0] kc;
        logic [4:0] sword;
        logic [4:0] bat;
        logic       acc;
    } kvec_t;
    kvec_t tbl [8];

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v, input int n);
        int         taps [4] = '{8, 6, 5, 4};
        logic [7:0] mask = 8'h00;
        logic [7:0] r = v;
        for (int i = 0; i < 4; i++) mask[taps[i]-1] = 1'b1;
        for (int k = 0; k < n; k++) r = r[0] ? ((r >> 1) ^ mask) : (r >> 1);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, m_cyc);
        end
    endtask

    task automatic model_clear();
        m_ph = PH_IDLE; m_left = 0; m_idle = 0; m_turns = 0;
        m_pch = 2'b00; m_ech = 2'b00; m_win = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently presented to the DUT.
    task automatic model_update();
        logic       coll, start, legal;
        logic [7:0] l_now;
        logic [1:0] pick;
        coll  = bus.collision_detected;
        l_now = m_lfsr;
        if (rst) begin
            model_clear();
            m_lfsr = SEED;
            m_prev = 1'b0;
            return;
        end
        m_lfsr = lfsr_adv(l_now, 1);
        start  = coll && !m_prev;
        m_prev = coll;
        if (!coll && m_ph != PH_IDLE) begin
            model_clear();
            return;
        end
        case (m_ph)
            PH_IDLE: if (start) begin m_ph = PH_START; m_turns = 0; end
            PH_START: begin m_ph = PH_WAIT; m_idle = 0; end
            PH_WAIT: begin
                legal = (bus.key_choice == 2'd0) || (bus.key_choice == 2'd1) ||
                        (bus.key_choice == 2'd2 && bus.player_bat_left != 0) ||
                        (bus.key_choice == 2'd3 && bus.player_sword_left != 0);
                if (bus.key_valid && legal) begin
                    m_pch = bus.key_choice; m_ph = PH_PSTRIKE; m_turns = (m_turns < 255) ? m_turns + 1 : 255;
                end else if (TMO_EN && m_idle + 1 == TMO) begin
                    m_pch = 2'b00; m_ph = PH_PSTRIKE; m_turns = (m_turns < 255) ? m_turns + 1 : 255;
                end else begin
                    m_idle++;
                end
            end
            PH_PSTRIKE: begin m_ph = PH_PSETTLE; m_left = SET; end
            PH_PSETTLE: begin
                m_left--;
                if (m_left == 0) begin
                    if (bus.player_win_in)     begin m_ph = PH_OVER; m_win = 1'b1; end
                    else if (bus.enemy_win_in) begin m_ph = PH_OVER; m_win = 1'b0; end
                    else                       begin m_ph = PH_THINK; m_left = THK; end
                end
            end
            PH_THINK: begin
                m_left--;
                if (m_left == 0) begin
                    pick = l_now[1:0];
                    if ((pick == 2'd2 && bus.enemy_bat_left == 0) || (pick == 2'd3 && bus.enemy_sword_left == 0))
                        pick = 2'd1;
                    m_ech = pick; m_ph = PH_ESTRIKE; m_turns = (m_turns < 255) ? m_turns + 1 : 255;
                end
            end
            PH_ESTRIKE: begin m_ph = PH_ESETTLE; m_left = SET; end
            PH_ESETTLE: begin
                m_left--;
                if (m_left == 0) begin
                    if (bus.enemy_win_in)       begin m_ph = PH_OVER; m_win = 1'b0; end
                    else if (bus.player_win_in) begin m_ph = PH_OVER; m_win = 1'b1; end
                    else                        begin m_ph = PH_WAIT; m_idle = 0; end
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        chk("player_turn",   bus.player_turn,   m_ph == PH_PSTRIKE);
        chk("attacker_turn", bus.attacker_turn, m_ph == PH_ESTRIKE);
        chk("player_choice", bus.player_choice, m_pch);
        chk("enemy_choice",  bus.enemy_choice,  m_ech);
        chk("battle_active", bus.battle_active, m_ph >= PH_START && m_ph <= PH_ESETTLE);
        chk("awaiting_key",  bus.awaiting_key,  m_ph == PH_WAIT);
        chk("turn_count",    bus.turn_count,    8'(m_turns));
        chk("battle_over",   bus.battle_over,   m_ph == PH_OVER);
        chk("winner",        bus.winner,        m_win);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        m_cyc++;
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n, cyc_p, seen;
        logic [7:0] l15;

        tbl[0] = '{2'd0, 5'd0,  5'd0,  1'b1};
        tbl[1] = '{2'd1, 5'd0,  5'd0,  1'b1};
        tbl[2] = '{2'd2, 5'd0,  5'd3,  1'b1};
        tbl[3] = '{2'd2, 5'd3,  5'd0,  1'b0};
        tbl[4] = '{2'd3, 5'd0,  5'd3,  1'b0};
        tbl[5] = '{2'd3, 5'd3,  5'd0,  1'b1};
        tbl[6] = '{2'd2, 5'd31, 5'd31, 1'b1};
        tbl[7] = '{2'd3, 5'd1,  5'd1,  1'b1};

        rst = 1'b1;
        bus.collision_detected = 1'b0; bus.key_valid = 1'b0; bus.key_choice = 2'd0;
        bus.player_sword_left = 5'd5; bus.player_bat_left = 5'd5;
        bus.enemy_sword_left = 5'd5; bus.enemy_bat_left = 5'd5;
        bus.player_win_in = 1'b0; bus.enemy_win_in = 1'b0;
        model_clear(); m_lfsr = SEED; m_prev = 1'b0;

        // Reset state.
        step(); step();
        chk("rst_over", bus.battle_over, 8'd0);
        chk("rst_turns", bus.turn_count, 8'd0);
        rst = 1'b0;

        // Align the LFSR so the enemy pick lands on lfsr[1:0]=10 (bat) with no bats left.
        bus.enemy_bat_left = 5'd0;
        n = 0;
        l15 = lfsr_adv(m_lfsr, 15);
        while (l15[1:0] != 2'b10 && n < 300) begin
            step(); n++;
            l15 = lfsr_adv(m_lfsr, 15);
        end
        chk("lfsr_align_bound", 8'(n < 300), 8'd1);

        bus.collision_detected = 1'b1;
        step();
        chk("start_active", bus.battle_active, 8'd1);
        chk("start_await", bus.awaiting_key, 8'd0);
        step();
        chk("wait_await", bus.awaiting_key, 8'd1);
        chk("wait_turns", bus.turn_count, 8'd0);

        bus.player_sword_left = 5'd0; bus.key_valid = 1'b1; bus.key_choice = 2'd3;
        step();
        chk("reject_S_pturn", bus.player_turn, 8'd0);
        chk("reject_S_await", bus.awaiting_key, 8'd1);
        bus.key_choice = 2'd1;
        step();
        bus.key_valid = 1'b0;
        chk("accept_K_pturn", bus.player_turn, 8'd1);
        chk("accept_K_choice", bus.player_choice, 8'd1);
        chk("accept_K_turns", bus.turn_count, 8'd1);
        cyc_p = m_cyc;
        step();
        chk("pturn_one_cycle", bus.player_turn, 8'd0);

        n = 0;
        while (bus.attacker_turn !== 1'b1 && n < 40) begin step(); n++; end
        chk("enemy_gap", 8'(m_cyc - cyc_p), 8'(THK + SET + 1));
        chk("enemy_degraded", bus.enemy_choice, 8'd1);
        chk("enemy_turns", bus.turn_count, 8'd2);
        n = 0;
        while (bus.awaiting_key !== 1'b1 && n < 10) begin step(); n++; end
        chk("back_to_wait", bus.awaiting_key, 8'd1);

        // Player wins on the last settle cycle.
        bus.key_valid = 1'b1; bus.key_choice = 2'd0;
        step();
        bus.key_valid = 1'b0;
        for (int i = 0; i < SET; i++) step();
        bus.player_win_in = 1'b1;
        step();
        bus.player_win_in = 1'b0;
        chk("pwin_over", bus.battle_over, 8'd1);
        chk("pwin_winner", bus.winner, 8'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin step(); if (bus.attacker_turn === 1'b1) seen++; end
        chk("pwin_no_enemy", 8'(seen), 8'd0);
        bus.collision_detected = 1'b0;
        step();
        chk("over_exit", bus.battle_over, 8'd0);

        // Collision drops during enemy think.
        bus.collision_detected = 1'b1;
        step(); step();
        bus.key_valid = 1'b1; bus.key_choice = 2'd0;
        step();
        bus.key_valid = 1'b0;
        for (int i = 0; i < SET + 2; i++) step();
        bus.collision_detected = 1'b0;
        step();
        chk("abort_active", bus.battle_active, 8'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin step(); if (bus.attacker_turn === 1'b1) seen++; end
        chk("abort_no_enemy", 8'(seen), 8'd0);

        // Key legality table.
        foreach (tbl[i]) begin
            bus.collision_detected = 1'b1;
            step(); step();
            bus.key_valid = 1'b1; bus.key_choice = tbl[i].kc;
            bus.player_sword_left = tbl[i].sword; bus.player_bat_left = tbl[i].bat;
            step();
            bus.key_valid = 1'b0;
            chk("key_tbl_accept", bus.player_turn, 8'(tbl[i].acc));
            if (tbl[i].acc) chk("key_tbl_choice", bus.player_choice, 8'(tbl[i].kc));
            bus.collision_detected = 1'b0;
            step();
        end

        // Turn counter saturation.
        bus.collision_detected = 1'b1; bus.key_valid = 1'b1; bus.key_choice = 2'd0;
        for (int i = 0; i < 2300; i++) step();
        chk("turns_saturate", bus.turn_count, 8'd255);
        bus.collision_detected = 1'b0; bus.key_valid = 1'b0;
        step();

`ifdef TURN_TIMEOUT_EN
        bus.collision_detected = 1'b1;
        step(); step();
        n = 0;
        while (bus.player_turn !== 1'b1 && n < 20) begin step(); n++; end
        chk("timeout_wait", 8'(n), 8'(TMO));
        chk("timeout_choice", bus.player_choice, 8'd0);
        bus.collision_detected = 1'b0;
        step();
`endif

        // Randomized battles against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if (bus.collision_detected) bus.collision_detected = ($urandom_range(0, 59) != 0);
            else                        bus.collision_detected = ($urandom_range(0, 3) == 0);
            bus.key_valid         = ($urandom_range(0, 3) == 0);
            bus.key_choice        = 2'($urandom_range(0, 3));
            bus.player_sword_left = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.player_bat_left   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.enemy_sword_left  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.enemy_bat_left    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.player_win_in     = ($urandom_range(0, 19) == 0);
            bus.enemy_win_in      = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
